// File: rtl/ems_page_mapper.sv
// ems_page_mapper
//
// Expanded-memory page mapper. Page registers are written through a small
// I/O port block. Memory cycles that fall inside the EMS frame are translated
// into a physical SDRAM page address, which is latched when the command starts.
//
// Optional feature: define EMS_READBACK_EN to let I/O reads of the page ports
// return register contents. Without it, the readback outputs are tied to 0.
//
// Ports:
//   clock              chipset clock
//   reset              synchronous, active-high
//   address            20-bit bus address from the arbiter
//   internal_data_bus  8-bit bus write data
//   io_write_n         I/O write command, active low
//   io_read_n          I/O read command, active low
//   memory_read_n      memory read command, active low
//   memory_write_n     memory write command, active low
//   address_enable_n   low while DMA owns the bus
//   ems_enabled        master enable
//   ems_address        I/O base select (0x208/0x218/0x258/0x268)
//   ems_select         current memory cycle is in an enabled EMS window
//   ems_phys_address   translated address {page, address[13:0]}
//   data_bus_out       readback data
//   data_bus_out_valid readback drive enable
module ems_page_mapper #(
  parameter int          NUM_PAGES  = 4,
  parameter int          PAGE_BITS  = 7,
  parameter logic [19:0] FRAME_BASE = 20'hD0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [19:0]            address,
  input  logic [7:0]             internal_data_bus,
  input  logic                   io_write_n,
  input  logic                   io_read_n,
  input  logic                   memory_read_n,
  input  logic                   memory_write_n,
  input  logic                   address_enable_n,
  input  logic                   ems_enabled,
  input  logic [1:0]             ems_address,
  output logic                   ems_select,
  output logic [PAGE_BITS+13:0]  ems_phys_address,
  output logic [7:0]             data_bus_out,
  output logic                   data_bus_out_valid
);

  localparam logic [20:0] FRAME_LO    = {1'b0, FRAME_BASE};
  localparam logic [20:0] FRAME_HI    = FRAME_LO + 21'(NUM_PAGES * 16384);
  localparam logic [2:0]  WIN_MASK    = 3'(NUM_PAGES - 1);
  localparam logic [3:0]  NUM_PAGES_4 = 4'(NUM_PAGES);

  // ---------------- I/O decode ----------------
  logic [9:0] io_base;
  always_comb begin
    io_base = 10'h208;
    case (ems_address)
      2'b00: io_base = 10'h208;
      2'b01: io_base = 10'h218;
      2'b10: io_base = 10'h258;
      2'b11: io_base = 10'h268;
      default: io_base = 10'h208;
    endcase
  end

  logic [2:0] io_index;
  logic       io_hit;
  assign io_index = address[2:0];
  assign io_hit   = (address[9:3] == io_base[9:3]) && (address[19:10] == 10'd0) &&
                    address_enable_n && ems_enabled &&
                    ({1'b0, io_index} < NUM_PAGES_4);

  // Edge-detect history resets to 1. The armed flag also requires the
  // command to be seen high once after reset, so a command held low through
  // reset is ignored until it produces a genuine falling edge.
  logic io_write_prev_reg, io_write_armed_reg;
  logic io_write_hit;
  assign io_write_hit = io_write_prev_reg & io_write_armed_reg & ~io_write_n & io_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_write_prev_reg  <= 1'b1;
      io_write_armed_reg <= 1'b0;
    end else begin
      io_write_prev_reg  <= io_write_n;
      io_write_armed_reg <= io_write_armed_reg | io_write_n;
    end
  end

  // ---------------- page registers ----------------
  logic [NUM_PAGES-1:0] en_vec;
  logic [PAGE_BITS-1:0] page_vec [NUM_PAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAGES; gi++) begin : g_page
      logic                 en_reg;
      logic [PAGE_BITS-1:0] page_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          en_reg   <= 1'b0;
          page_reg <= '0;
        end else if (io_write_hit && (io_index == 3'(gi))) begin
          // Bit 7 set disables the window but keeps the stored page.
          if (internal_data_bus[7]) begin
            en_reg <= 1'b0;
          end else begin
            en_reg   <= 1'b1;
            page_reg <= internal_data_bus[PAGE_BITS-1:0];
          end
        end
      end

      assign en_vec[gi]   = en_reg;
      assign page_vec[gi] = page_reg;
    end
  endgenerate

  // ---------------- memory translation ----------------
  logic [2:0]           window;
  logic                 frame_hit;
  logic                 win_en;
  logic [PAGE_BITS-1:0] win_page;

  assign window    = address[16:14] & WIN_MASK;
  assign frame_hit = ({1'b0, address} >= FRAME_LO) && ({1'b0, address} < FRAME_HI);

  always_comb begin
    win_en   = 1'b0;
    win_page = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (window == 3'(i)) begin
        win_en   = en_vec[i];
        win_page = page_vec[i];
      end
    end
  end

  logic mem_cmd_n;
  logic mem_prev_reg, mem_armed_reg;
  logic mem_fall;
  logic                  ems_select_reg;
  logic [PAGE_BITS+13:0] ems_phys_reg;

  assign mem_cmd_n = memory_read_n & memory_write_n;
  assign mem_fall  = mem_prev_reg & mem_armed_reg & ~mem_cmd_n;

  // The translation is captured once per command and held until both
  // commands are high again. Page writes during the command don't disturb it.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_prev_reg   <= 1'b1;
      mem_armed_reg  <= 1'b0;
      ems_select_reg <= 1'b0;
      ems_phys_reg   <= '0;
    end else begin
      mem_prev_reg  <= mem_cmd_n;
      mem_armed_reg <= mem_armed_reg | mem_cmd_n;
      if (mem_fall) begin
        ems_select_reg <= frame_hit & win_en & ems_enabled;
        ems_phys_reg   <= {win_page, address[13:0]};
      end else if (mem_cmd_n) begin
        ems_select_reg <= 1'b0;
        ems_phys_reg   <= '0;
      end
    end
  end

  assign ems_select       = ems_select_reg;
  assign ems_phys_address = ems_phys_reg;

  // ---------------- optional readback ----------------
`ifdef EMS_READBACK_EN
  logic                 rd_en;
  logic [PAGE_BITS-1:0] rd_page;
  logic                 io_read_prev_reg, io_read_armed_reg;
  logic                 rb_valid_reg;
  logic [7:0]           rb_data_reg;

  always_comb begin
    rd_en   = 1'b0;
    rd_page = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (io_index == 3'(i)) begin
        rd_en   = en_vec[i];
        rd_page = page_vec[i];
      end
    end
  end

  // Valid starts on the read falling edge and is held while the read
  // stays low and the address keeps hitting.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_read_prev_reg  <= 1'b1;
      io_read_armed_reg <= 1'b0;
      rb_valid_reg      <= 1'b0;
      rb_data_reg       <= 8'd0;
    end else begin
      io_read_prev_reg  <= io_read_n;
      io_read_armed_reg <= io_read_armed_reg | io_read_n;
      if (io_hit && !io_read_n &&
          ((io_read_prev_reg && io_read_armed_reg) || rb_valid_reg)) begin
        rb_valid_reg <= 1'b1;
        rb_data_reg  <= {~rd_en, 7'(rd_page)};
      end else begin
        rb_valid_reg <= 1'b0;
        rb_data_reg  <= 8'd0;
      end
    end
  end

  assign data_bus_out       = rb_data_reg;
  assign data_bus_out_valid = rb_valid_reg;
`else
  logic unused_io_read;
  assign unused_io_read     = io_read_n;
  assign data_bus_out       = 8'd0;
  assign data_bus_out_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ems_page_mapper.sv
module tb_ems_page_mapper;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        io_write_n, io_read_n, memory_read_n, memory_write_n;
  logic        address_enable_n, ems_enabled;
  logic [1:0]  ems_address;
  logic        ems_select;
  logic [20:0] ems_phys_address;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_valid;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  ems_page_mapper dut (
    .clock              (clock),
    .reset              (reset),
    .address            (address),
    .internal_data_bus  (internal_data_bus),
    .io_write_n         (io_write_n),
    .io_read_n          (io_read_n),
    .memory_read_n      (memory_read_n),
    .memory_write_n     (memory_write_n),
    .address_enable_n   (address_enable_n),
    .ems_enabled        (ems_enabled),
    .ems_address        (ems_address),
    .ems_select         (ems_select),
    .ems_phys_address   (ems_phys_address),
    .data_bus_out       (data_bus_out),
    .data_bus_out_valid (data_bus_out_valid)
  );

  typedef enum logic [1:0] {OP_IOW, OP_MEMR, OP_IOR} op_e;

  typedef struct {
    op_e         op;
    logic [1:0]  ea;
    logic        ena;
    logic        aen;
    logic [19:0] addr;
    logic [7:0]  data;
    logic        exp_sel;
    logic [20:0] exp_phys;
    logic        exp_rvalid;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(op_e op, logic [1:0] ea, logic ena, logic aen,
                              logic [19:0] addr, logic [7:0] data, logic exp_sel,
                              logic [20:0] exp_phys, logic exp_rvalid, logic [7:0] exp_rdata);
    vec_t v;
    v.op = op; v.ea = ea; v.ena = ena; v.aen = aen; v.addr = addr; v.data = data;
    v.exp_sel = exp_sel; v.exp_phys = exp_phys; v.exp_rvalid = exp_rvalid; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_iow(input logic [19:0] a, input logic [7:0] d);
    @(negedge clock);
    address = a; internal_data_bus = d; io_write_n = 1'b0;
    @(negedge clock);
    io_write_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_memr(input string name, input logic [19:0] a,
                         input logic e_sel, input logic [20:0] e_phys);
    @(negedge clock);
    address = a; memory_read_n = 1'b0;
    @(negedge clock);
    check({name, "_sel"}, 32'(ems_select), 32'(e_sel));
    check({name, "_phys"}, 32'(ems_phys_address), 32'(e_phys));
    memory_read_n = 1'b1;
    @(negedge clock);
    check({name, "_clr_sel"}, 32'(ems_select), 32'd0);
    check({name, "_clr_phys"}, 32'(ems_phys_address), 32'd0);
  endtask

  task automatic do_ior(input string name, input logic [19:0] a,
                        input logic e_valid, input logic [7:0] e_data);
    logic       v;
    logic [7:0] d;
`ifdef EMS_READBACK_EN
    v = e_valid; d = e_valid ? e_data : 8'd0;
`else
    v = 1'b0; d = 8'd0;
`endif
    @(negedge clock);
    address = a; io_read_n = 1'b0;
    @(negedge clock);
    check({name, "_valid"}, 32'(data_bus_out_valid), 32'(v));
    check({name, "_data"}, 32'(data_bus_out), 32'(d));
    @(negedge clock);
    check({name, "_hold"}, 32'(data_bus_out_valid), 32'(v));
    io_read_n = 1'b1;
    @(negedge clock);
    check({name, "_clr"}, 32'(data_bus_out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = '0; internal_data_bus = '0;
    io_write_n = 1'b1; io_read_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
    address_enable_n = 1'b1; ems_enabled = 1'b1; ems_address = 2'b01;

    //   op       ea    ena   aen   addr        data   sel   phys        rv    rdata
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h00219, 8'h05, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD4123, 8'h00, 1'b1, 21'h14123,  1'b0, 8'h00);
    add(OP_IOR,  2'b01, 1'b1, 1'b1, 20'h00219, 8'h00, 1'b0, 21'h0,      1'b1, 8'h05);
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h00219, 8'h80, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD4000, 8'h00, 1'b0, 21'h14000,  1'b0, 8'h00);
    add(OP_IOR,  2'b01, 1'b1, 1'b1, 20'h00219, 8'h00, 1'b0, 21'h0,      1'b1, 8'h85);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD0000, 8'h00, 1'b0, 21'h00000,  1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h0021C, 8'h03, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD0005, 8'h00, 1'b0, 21'h00005,  1'b0, 8'h00);
    add(OP_IOR,  2'b01, 1'b1, 1'b1, 20'h0021C, 8'h00, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h00209, 8'h01, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD4000, 8'h00, 1'b0, 21'h14000,  1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h0021B, 8'h7F, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hDFFFF, 8'h00, 1'b1, 21'h1FFFFF, 1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hE0000, 8'h00, 1'b0, 21'h00000,  1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hCFFFF, 8'h00, 1'b0, 21'h1FFFFF, 1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h00218, 8'h01, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD0010, 8'h00, 1'b1, 21'h04010,  1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b1, 1'b0, 20'h00218, 8'h02, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b0, 20'hD0010, 8'h00, 1'b1, 21'h04010,  1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b0, 1'b1, 20'h00218, 8'h03, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b0, 1'b1, 20'hD0010, 8'h00, 1'b0, 21'h04010,  1'b0, 8'h00);
    add(OP_MEMR, 2'b01, 1'b1, 1'b1, 20'hD0010, 8'h00, 1'b1, 21'h04010,  1'b0, 8'h00);
    add(OP_IOW,  2'b11, 1'b1, 1'b1, 20'h0026A, 8'h0A, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b11, 1'b1, 1'b1, 20'hD8001, 8'h00, 1'b1, 21'h28001,  1'b0, 8'h00);
    add(OP_IOW,  2'b00, 1'b1, 1'b1, 20'h0020A, 8'h0B, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b00, 1'b1, 1'b1, 20'hD8002, 8'h00, 1'b1, 21'h2C002,  1'b0, 8'h00);
    add(OP_IOW,  2'b10, 1'b1, 1'b1, 20'h0025A, 8'h0C, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_MEMR, 2'b10, 1'b1, 1'b1, 20'hD8003, 8'h00, 1'b1, 21'h30003,  1'b0, 8'h00);
    add(OP_IOW,  2'b01, 1'b1, 1'b1, 20'h00219, 8'h05, 1'b0, 21'h0,      1'b0, 8'h00);
    add(OP_IOR,  2'b01, 1'b0, 1'b1, 20'h00219, 8'h00, 1'b0, 21'h0,      1'b0, 8'h00);

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_sel", 32'(ems_select), 32'd0);
    check("rst_phys", 32'(ems_phys_address), 32'd0);
    check("rst_rvalid", 32'(data_bus_out_valid), 32'd0);
    check("rst_rdata", 32'(data_bus_out), 32'd0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      string nm;
      nm = $sformatf("v%0d", k);
      ems_address = vecs[k].ea; ems_enabled = vecs[k].ena; address_enable_n = vecs[k].aen;
      case (vecs[k].op)
        OP_IOW:  do_iow(vecs[k].addr, vecs[k].data);
        OP_MEMR: do_memr(nm, vecs[k].addr, vecs[k].exp_sel, vecs[k].exp_phys);
        default: do_ior(nm, vecs[k].addr, vecs[k].exp_rvalid, vecs[k].exp_rdata);
      endcase
      $display("vec %0d op=%0d ea=%0d ena=%0b aen=%0b addr=%05h data=%02h sel=%0b phys=%06h",
               k, vecs[k].op, vecs[k].ea, vecs[k].ena, vecs[k].aen, vecs[k].addr,
               vecs[k].data, ems_select, ems_phys_address);
    end
    ems_address = 2'b01; ems_enabled = 1'b1; address_enable_n = 1'b1;

    // Page write during an active command leaves the in-flight translation alone
    @(negedge clock);
    address = 20'hD4010; memory_read_n = 1'b0;
    @(negedge clock);
    check("mid_start", 32'(ems_phys_address), 32'h14010);
    address = 20'h00219; internal_data_bus = 8'h06; io_write_n = 1'b0;
    @(negedge clock);
    io_write_n = 1'b1;
    @(negedge clock);
    check("mid_hold_sel", 32'(ems_select), 32'd1);
    check("mid_hold_phys", 32'(ems_phys_address), 32'h14010);
    memory_read_n = 1'b1;
    @(negedge clock);
    check("mid_clr", 32'(ems_select), 32'd0);
    do_memr("mid_next", 20'hD4010, 1'b1, 21'h18010);
    $display("seq mid-command write done");

    // Back-to-back commands with no idle clock: no recapture
    @(negedge clock);
    address = 20'hD4020; memory_read_n = 1'b0;
    @(negedge clock);
    check("b2b_first", 32'(ems_phys_address), 32'h18020);
    memory_read_n = 1'b1; memory_write_n = 1'b0; address = 20'hD0030;
    @(negedge clock);
    check("b2b_hold_sel", 32'(ems_select), 32'd1);
    check("b2b_hold_phys", 32'(ems_phys_address), 32'h18020);
    memory_write_n = 1'b1;
    @(negedge clock);
    check("b2b_clr", 32'(ems_phys_address), 32'd0);
    $display("seq back-to-back done");

    // io_write_n held low for 10 clocks: only the first clock's data lands
    @(negedge clock);
    address = 20'h00218; internal_data_bus = 8'h02; io_write_n = 1'b0;
    @(negedge clock);
    internal_data_bus = 8'h07;
    repeat (9) @(negedge clock);
    io_write_n = 1'b1;
    @(negedge clock);
    do_memr("held_wr", 20'hD0010, 1'b1, 21'h08010);
    $display("seq held write done");

    // Reset in the middle of a command
    @(negedge clock);
    address = 20'hD4010; memory_read_n = 1'b0;
    @(negedge clock);
    check("rmid_pre", 32'(ems_select), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rmid_sel", 32'(ems_select), 32'd0);
    check("rmid_phys", 32'(ems_phys_address), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rmid_nocap_sel", 32'(ems_select), 32'd0);
    check("rmid_nocap_phys", 32'(ems_phys_address), 32'd0);
    memory_read_n = 1'b1;
    @(negedge clock);
    do_memr("post_rst", 20'hD4010, 1'b0, 21'h00010);
    do_ior("post_rst_rd", 20'h00219, 1'b1, 8'h80);
    $display("seq reset mid-command done");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ems_page_mapper.md
# ems_page_mapper

Parametrised expanded-memory page mapper for the chipset, replacing the fixed four-window EMS scheme. It decodes page-register writes on the I/O bus. It translates CPU/DMA memory cycles that fall in the EMS frame into a physical SDRAM page address, latched at command start. It sits beside the bus arbiter and feeds the RAM controller a select plus translated address.

## Interface
Parameters:
- NUM_PAGES, 4: number of 16 KB frame windows; power of two, 1..8.
- PAGE_BITS, 7: logical-page register width, 1..7 (max 2 MB of EMS).
- FRAME_BASE, 20'hD0000: frame start; must be aligned to NUM_PAGES*16 KB.

Ports:
- clock  in  1  chipset clock; only clock.
- reset  in  1  synchronous, active-high.
- address  in  20  bus address from arbiter.
- internal_data_bus  in  8  bus write data.
- io_write_n / io_read_n  in  1  I/O commands, active low.
- memory_read_n / memory_write_n  in  1  memory commands, active low.
- address_enable_n  in  1  low = DMA owns bus.
- ems_enabled  in  1  master enable.
- ems_address  in  2  I/O base select.
- ems_select  out  1  current memory cycle is in an enabled EMS window.
- ems_phys_address  out  PAGE_BITS+14  translated address {page, address[13:0]}.
- data_bus_out  out  8  readback data.
- data_bus_out_valid  out  1  readback drive enable.

## Operation
- I/O base: ems_address 00→0x208, 01→0x218, 10→0x258, 11→0x268. All bases are 8-aligned.
- An I/O hit requires all of the following:
  - address[9:3] == base[9:3];
  - address[19:10] == 0;
  - address_enable_n == 1;
  - ems_enabled == 1;
  - index = address[2:0] < NUM_PAGES.
  - Indices ≥ NUM_PAGES are ignored.
- Page write: fires on the first clock where io_write_n is low and was high the previous clock (falling-edge detect). This gives exactly one update per bus cycle.
  - data[7]=0 → en[index]=1, page[index]=data[PAGE_BITS-1:0].
  - data[7]=1 → en[index]=0; page[index] is unchanged.
- Frame hit: address in [FRAME_BASE, FRAME_BASE+NUM_PAGES*16K). Window = address[13+log2(NUM_PAGES):14].
- Memory translation: on the falling edge of (memory_read_n & memory_write_n), the following are captured into output registers:
  - hit & en[window] & ems_enabled;
  - page[window];
  - address[13:0].
- Captured values hold until both memory commands are high again. A page write during an active memory command does not alter the in-flight translation.
- Translation applies to CPU and DMA cycles alike.
- ems_enabled=0: no decode, no writes, ems_select forced 0. Register contents are retained.
- I/O and memory commands are processed independently. Both edges in one clock are both serviced.

## Timing
- Reset values:
  - all en=0, all page=0;
  - ems_select=0, ems_phys_address=0;
  - data_bus_out=0, data_bus_out_valid=0;
  - edge-detect history = 1 (no false edge after reset).
- Register write latency: the new value is visible to a memory command starting the next clock.
- ems_select / ems_phys_address are valid 1 clock after the command falling edge. They clear 1 clock after both commands return high.
- Back-to-back commands with no idle clock are treated as one command and are not re-captured. The arbiter always inserts ≥1 idle clock.
- Reset mid-command: all outputs go to 0 next clock. A command still low after reset is not captured until a new falling edge.
- Top frame byte (FRAME_BASE+NUM_PAGES*16K-1) hits; the next byte misses.

## Configuration
- EMS_READBACK_EN defined: an I/O read hit drives the register value.
  - data_bus_out = {~en[index], zero-extended page[index]}.
  - data_bus_out_valid=1 registered 1 clock after io_read_n falls, held while io_read_n is low and the address still hits.
  - Clears 1 clock after io_read_n rises.
- Undefined: data_bus_out=0 and data_bus_out_valid=0 permanently. Reads of page ports float to the external bus.

## Test plan
- Reset, ems_address=01, write 0x05 to 0x219, then memory read at 0xD4123 → ems_select=1, ems_phys_address=0x14123 (page 5, offset 0x0123), latency 1 clock.
- Write 0x80 to 0x219, read 0xD4000 → ems_select=0. Read 0xD0000 with window 0 never enabled → ems_select=0.
- Write 0x03 to 0x21C (index 4, NUM_PAGES=4) → no register changes. Write to 0x209 with ems_address=01 → ignored.
- Start a read at 0xD4010 with page 5, write 0x06 to 0x219 mid-command → output stays page 5. The next read at 0xD4010 → page 6.
- io_write_n held low 10 clocks writing 0x02 → exactly one update. Write 0x02 with address_enable_n=0 → ignored.
- With EMS_READBACK_EN, page 5 enabled at index 1, read 0x219 → data_bus_out=0x05, valid=1 after 1 clock. After disabling, read → 0x85. Without the macro → valid stays 0.
